// File: rtl/adder_chunked.sv
// adder_chunked: multi-cycle WIDTH-bit add/sub, CHUNK bits per cycle, valid/ready in (a,b,carry_in,sub) and out (sum,carry_out,overflow)
module adder_chunked #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_r, b_r;
  logic carry_r;
  logic [CHUNK-1:0] ca, cb, cs;
  logic cy, cm;
  int base;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign base = int'(cnt) * CHUNK;
  assign ca = a_r[base +: CHUNK];
  assign cb = b_r[base +: CHUNK];
  always_comb begin
    cy = carry_r;
    cm = 1'b0;
    cs = '0;
    for (int i = 0; i < CHUNK; i++) begin
      cs[i] = ca[i] ^ cb[i] ^ cy;
      cm = i == CHUNK - 1 ? cy : cm;
      cy = (ca[i] & cb[i]) | (cy & (ca[i] ^ cb[i]));
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      a_r <= '0;
      b_r <= '0;
      carry_r <= 1'b0;
      sum <= '0;
      carry_out <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r <= a;
          b_r <= sub ? ~b : b;
          carry_r <= sub ? 1'b1 : carry_in;
          cnt <= '0;
          state <= RUN;
        end
        RUN: begin
          sum[base +: CHUNK] <= cs;
          carry_r <= cy;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(NCHUNK - 1)) begin
            carry_out <= cy;
            overflow <= cy ^ cm;
            state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_chunked.sv
// tb_adder_chunked: scoreboard bench over four adder_chunked configurations (8/4, 32/4, 8/8, 8/1)
module tb_adder_chunked;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] iv = '0;
  logic [31:0] a = '0, b = '0;
  logic ci = 1'b0, sb = 1'b0, ordy = 1'b1;
  logic [3:0] irdy, ovld, cout, ovf;
  logic [7:0] s0, s2, s3;
  logic [31:0] s1;
  logic [31:0] sm [4];
  int wd [4] = '{8, 32, 8, 8};
  int ck [4] = '{4, 4, 8, 1};
  typedef struct {logic [31:0] s; logic co; logic ov;} exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  assign sm[0] = {24'b0, s0};
  assign sm[1] = s1;
  assign sm[2] = {24'b0, s2};
  assign sm[3] = {24'b0, s3};
  adder_chunked #(.WIDTH(8), .CHUNK(4)) u0 (.clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]),
    .a(a[7:0]), .b(b[7:0]), .carry_in(ci), .sub(sb), .out_valid(ovld[0]), .out_ready(ordy),
    .sum(s0), .carry_out(cout[0]), .overflow(ovf[0]));
  adder_chunked #(.WIDTH(32), .CHUNK(4)) u1 (.clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]),
    .a(a), .b(b), .carry_in(ci), .sub(sb), .out_valid(ovld[1]), .out_ready(ordy),
    .sum(s1), .carry_out(cout[1]), .overflow(ovf[1]));
  adder_chunked #(.WIDTH(8), .CHUNK(8)) u2 (.clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]),
    .a(a[7:0]), .b(b[7:0]), .carry_in(ci), .sub(sb), .out_valid(ovld[2]), .out_ready(ordy),
    .sum(s2), .carry_out(cout[2]), .overflow(ovf[2]));
  adder_chunked #(.WIDTH(8), .CHUNK(1)) u3 (.clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(irdy[3]),
    .a(a[7:0]), .b(b[7:0]), .carry_in(ci), .sub(sb), .out_valid(ovld[3]), .out_ready(ordy),
    .sum(s3), .carry_out(cout[3]), .overflow(ovf[3]));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic start_op(input int s, input logic [31:0] av, input logic [31:0] bv, input logic c, input logic sbv);
    logic [31:0] m, bop;
    logic [32:0] full;
    exp_t e;
    m = wd[s] == 32 ? 32'hFFFF_FFFF : (32'd1 << wd[s]) - 1;
    bop = (sbv ? ~bv : bv) & m;
    full = {1'b0, av & m} + {1'b0, bop} + 33'(sbv ? 1'b1 : c);
    e.s = full[31:0] & m;
    e.co = full[wd[s]];
    e.ov = (av[wd[s]-1] == bop[wd[s]-1]) && (e.s[wd[s]-1] != av[wd[s]-1]);
    q.push_back(e);
    @(negedge clk);
    chk("in_ready_idle", {31'b0, irdy[s]}, 1);
    a = av; b = bv; ci = c; sb = sbv; iv[s] = 1'b1;
    @(negedge clk);
    iv[s] = 1'b0;
  endtask
  task automatic wait_done(input int s);
    int n;
    exp_t e;
    n = 0;
    while (!ovld[s] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, wd[s] / ck[s]);
    e = q.pop_front();
    chk("sum", sm[s], e.s);
    chk("carry_out", {31'b0, cout[s]}, {31'b0, e.co});
    chk("overflow", {31'b0, ovf[s]}, {31'b0, e.ov});
  endtask
  task automatic finish_op(input int s);
    @(negedge clk);
    chk("back_idle_ready", {30'b0, irdy[s], ovld[s]}, 32'b10);
  endtask
  task automatic op(input int s, input logic [31:0] av, input logic [31:0] bv, input logic c, input logic sbv);
    start_op(s, av, bv, c, sbv);
    wait_done(s);
    finish_op(s);
  endtask
  initial begin
    logic [31:0] held;
    exp_t dump;
    #12;
    for (int s = 0; s < 4; s++) begin
      chk("rst_ready_valid", {30'b0, irdy[s], ovld[s]}, 32'b10);
      chk("rst_outs", {sm[s][30:0], cout[s]} ^ {31'b0, ovf[s]}, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    op(0, 32'hFF, 32'h01, 1'b0, 1'b0);
    op(0, 32'h7F, 32'h01, 1'b0, 1'b0);
    op(0, 32'h80, 32'h80, 1'b0, 1'b0);
    op(0, 32'h05, 32'h07, 1'b1, 1'b1);
    op(0, 32'h10, 32'h03, 1'b0, 1'b1);
    ordy = 1'b0;
    start_op(0, 32'h3C, 32'h5A, 1'b1, 1'b0);
    wait_done(0);
    held = sm[0];
    for (int i = 0; i < 5; i++) begin
      a = 32'h11 * i; iv[0] = 1'b1;
      @(negedge clk);
      iv[0] = 1'b0;
      chk("bp_valid_ready", {30'b0, ovld[0], irdy[0]}, 32'b10);
      chk("bp_sum_hold", sm[0], held);
    end
    ordy = 1'b1;
    @(negedge clk);
    chk("bp_release", {30'b0, irdy[0], ovld[0]}, 32'b10);
    chk("bp_sum_kept", sm[0], held);
    start_op(1, 32'hDEAD_BEEF, 32'h0123_4567, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrun_rst_ready_valid", {30'b0, irdy[1], ovld[1]}, 32'b10);
    chk("midrun_rst_sum", sm[1], 0);
    chk("midrun_rst_flags", {30'b0, cout[1], ovf[1]}, 0);
    dump = q.pop_front();
    @(negedge clk);
    rst = 1'b0;
    op(1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    op(1, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1);
    op(1, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    for (int s = 2; s < 4; s++)
      for (int i = 0; i < 1000; i++)
        op(s, $urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
